multicycle_controller: RTL and testbench

//  Multi-cycle RV32I control FSM that sequences the CPU datapath. Decodes irOut,

---
 rtl/multicycle_controller_if.sv | 32 +++
 rtl/multicycle_controller.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Control/feedback bundle between the multicycle controller (master) and the RV32I datapath (slave).
interface multicycle_controller_if #(
    parameter int unsigned DWIDTH = 32
);
    logic [DWIDTH-1:0] irOut;
    logic              comparatorOut;
    logic              irEn;
    logic              pcEn;
    logic [1:0]        pcSelect;
    logic              regWrite;
    logic              aluSrc;
    logic              ramRdEn;
    logic              ramWrEn;
    logic              isByte;
    logic              isHalf;
    logic              isWord;
    logic [1:0]        memToReg;
    logic [2:0]        state_dbg;
    logic              halted;

    modport master (
        input  irOut, comparatorOut,
        output irEn, pcEn, pcSelect, regWrite, aluSrc, ramRdEn, ramWrEn,
               isByte, isHalf, isWord, memToReg, state_dbg, halted
    );

    modport slave (
        output irOut, comparatorOut,
        input  irEn, pcEn, pcSelect, regWrite, aluSrc, ramRdEn, ramWrEn,
               isByte, isHalf, isWord, memToReg, state_dbg, halted
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WB(/HALT) sequencing of datapath enables.
// Optional feature: define ILLEGAL_TRAP_EN to trap illegal encodings into HALT (default: execute as NOP).
module multicycle_controller #(
    parameter int unsigned DWIDTH  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_controller_if.master ctrl_io
);
    localparam int unsigned   CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5
    } state_e;

    typedef struct packed {
        logic       irEn;
        logic       pcEn;
        logic [1:0] pcSelect;
        logic       regWrite;
        logic       aluSrc;
        logic       ramRdEn;
        logic       ramWrEn;
        logic       isByte;
        logic       isHalf;
        logic       isWord;
        logic [1:0] memToReg;
        logic       halted;
    } ctrl_t;

    localparam ctrl_t CTRL_FETCH = '{irEn: 1'b1, default: '0};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl_q, ctrl_d;

    logic [DWIDTH-1:0] ir;
    logic [6:0]        opcode;
    logic [1:0]        size;
    logic              is_load, is_store, is_ls, illegal;
    logic              unused_c;

    assign ir       = ctrl_io.irOut;
    assign opcode   = ir[6:0];
    assign size     = ir[13:12];
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign is_ls    = is_load | is_store;
    // Branch resolution happens in the datapath via pcSelect=11; the controller only routes it.
    assign unused_c = ^{ctrl_io.comparatorOut, ir[DWIDTH-1:14], ir[11:7]};

    always_comb begin
        illegal = !(opcode inside {OP_R, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
                                   OP_BRANCH, OP_LOAD, OP_STORE, OP_FENCE, OP_SYSTEM})
                  || (is_ls && (size == 2'b11));
    end

    // Next state and MEM latency counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE:  state_d = S_EXECUTE;
            S_EXECUTE: begin
                if (illegal) begin
                    state_d = TRAP_EN ? S_HALT : S_FETCH;
                end else if (is_ls) begin
                    state_d = S_MEM;
                    cnt_d   = '0;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) state_d = is_load ? S_WB : S_FETCH;
            end
            S_WB:      state_d = S_FETCH;
            S_HALT:    state_d = TRAP_EN ? S_HALT : S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // Outputs for the upcoming cycle, so every control line leaves a flop.
    always_comb begin
        ctrl_d = '0;
        unique case (state_d)
            S_FETCH: ctrl_d.irEn = 1'b1;
            S_EXECUTE: begin
                unique case (opcode)
                    OP_R:     ctrl_d.regWrite = 1'b1;
                    OP_IMM:   begin ctrl_d.regWrite = 1'b1; ctrl_d.aluSrc = 1'b1; end
                    OP_LUI:   begin ctrl_d.regWrite = 1'b1; ctrl_d.memToReg = 2'b11; end
                    OP_AUIPC: begin ctrl_d.regWrite = 1'b1; ctrl_d.aluSrc = 1'b1; end
                    OP_JAL:   begin
                        ctrl_d.regWrite = 1'b1; ctrl_d.memToReg = 2'b10; ctrl_d.pcSelect = 2'b01;
                    end
                    OP_JALR:  begin
                        ctrl_d.regWrite = 1'b1; ctrl_d.aluSrc = 1'b1;
                        ctrl_d.memToReg = 2'b10; ctrl_d.pcSelect = 2'b10;
                    end
                    OP_BRANCH:          ctrl_d.pcSelect = 2'b11;
                    OP_LOAD, OP_STORE:  ctrl_d.aluSrc = 1'b1;
                    default: ;
                endcase
                if (illegal) begin
                    ctrl_d      = '0;
                    ctrl_d.pcEn = !TRAP_EN;
                end else begin
                    ctrl_d.pcEn = !is_ls;
                end
            end
            S_MEM: begin
                ctrl_d.aluSrc  = 1'b1;
                ctrl_d.ramRdEn = is_load;
                ctrl_d.ramWrEn = is_store;
                ctrl_d.isByte  = (size == 2'b00);
                ctrl_d.isHalf  = (size == 2'b01);
                ctrl_d.isWord  = (size == 2'b10);
                ctrl_d.pcEn    = is_store && (cnt_d == CNT_LAST);
            end
            S_WB: begin
                ctrl_d.regWrite = 1'b1;
                ctrl_d.memToReg = 2'b01;
                ctrl_d.isByte   = (size == 2'b00);
                ctrl_d.isHalf   = (size == 2'b01);
                ctrl_d.isWord   = (size == 2'b10);
                ctrl_d.pcEn     = 1'b1;
            end
            S_HALT:  ctrl_d.halted = TRAP_EN;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            ctrl_q  <= CTRL_FETCH;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Reset blanks every output immediately, so no partial write survives a mid-instruction reset.
    assign ctrl_io.irEn      = ctrl_q.irEn     & ~reset;
    assign ctrl_io.pcEn      = ctrl_q.pcEn     & ~reset;
    assign ctrl_io.pcSelect  = ctrl_q.pcSelect & {2{~reset}};
    assign ctrl_io.regWrite  = ctrl_q.regWrite & ~reset;
    assign ctrl_io.aluSrc    = ctrl_q.aluSrc   & ~reset;
    assign ctrl_io.ramRdEn   = ctrl_q.ramRdEn  & ~reset;
    assign ctrl_io.ramWrEn   = ctrl_q.ramWrEn  & ~reset;
    assign ctrl_io.isByte    = ctrl_q.isByte   & ~reset;
    assign ctrl_io.isHalf    = ctrl_q.isHalf   & ~reset;
    assign ctrl_io.isWord    = ctrl_q.isWord   & ~reset;
    assign ctrl_io.memToReg  = ctrl_q.memToReg & {2{~reset}};
    assign ctrl_io.halted    = ctrl_q.halted   & ~reset;
    assign ctrl_io.state_dbg = reset ? 3'(S_FETCH) : 3'(state_q);
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller (MEM_LAT=2); honours ILLEGAL_TRAP_EN for the illegal-opcode case.
module tb_multicycle_controller;
    localparam int unsigned MEM_LAT = 2;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_LW   = 32'h0000A103;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_SB   = 32'h00208023;
    localparam logic [31:0] I_JAL  = 32'h0000006F;
    localparam logic [31:0] I_JALR = 32'h00008067;
    localparam logic [31:0] I_LUI  = 32'h123450B7;
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_controller_if #(.DWIDTH(32)) bus ();

    multicycle_controller #(.DWIDTH(32), .MEM_LAT(MEM_LAT)) dut (
        .clk     (clk),
        .reset   (reset),
        .ctrl_io (bus)
    );

    typedef struct {
        string       nm;
        logic [16:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Field order: irEn pcEn pcSel regWrite aluSrc ramRd ramWr byte half word memToReg halted state
    function automatic logic [16:0] ev(input logic ie, pe, input logic [1:0] ps,
                                       input logic rw, as, rd, wr, b, h, w,
                                       input logic [1:0] m2r, input logic hl, input logic [2:0] st);
        return {ie, pe, ps, rw, as, rd, wr, b, h, w, m2r, hl, st};
    endfunction

    logic [16:0] act;
    assign act = {bus.irEn, bus.pcEn, bus.pcSelect, bus.regWrite, bus.aluSrc, bus.ramRdEn,
                  bus.ramWrEn, bus.isByte, bus.isHalf, bus.isWord, bus.memToReg, bus.halted,
                  bus.state_dbg};

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_checks++;
                if (act !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: got %b required %b", e.nm, act, e.v);
                end
            end
        end
    end

    task automatic cyc(input string nm, input logic rst, input logic [31:0] ir,
                       input logic cmp, input logic [16:0] e);
        @(posedge clk);
        #1;
        reset             = rst;
        bus.irOut         = ir;
        bus.comparatorOut = cmp;
        sb.push_back('{nm: nm, v: e});
    endtask

    logic [16:0] E_ZERO, E_FETCH, E_DEC;

    task automatic fetch_decode(input string nm, input logic [31:0] ir, input logic cmp);
        cyc({nm, " fetch"},  1'b0, ir, cmp, E_FETCH);
        cyc({nm, " decode"}, 1'b0, ir, cmp, E_DEC);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        E_ZERO  = ev(0,0,2'b00,0,0,0,0,0,0,0,2'b00,0,3'd0);
        E_FETCH = ev(1,0,2'b00,0,0,0,0,0,0,0,2'b00,0,3'd0);
        E_DEC   = ev(0,0,2'b00,0,0,0,0,0,0,0,2'b00,0,3'd1);
        reset             = 1'b1;
        bus.irOut         = '0;
        bus.comparatorOut = 1'b0;

        cyc("reset c0", 1'b1, 32'h0, 1'b0, E_ZERO);
        cyc("reset c1", 1'b1, 32'h0, 1'b0, E_ZERO);

        // Release lands on the ADD fetch cycle.
        fetch_decode("add", I_ADD, 1'b0);
        cyc("add exec", 1'b0, I_ADD, 1'b0, ev(0,1,2'b00,1,0,0,0,0,0,0,2'b00,0,3'd2));

        fetch_decode("lw", I_LW, 1'b0);
        cyc("lw exec", 1'b0, I_LW, 1'b0, ev(0,0,2'b00,0,1,0,0,0,0,0,2'b00,0,3'd2));
        cyc("lw mem0", 1'b0, I_LW, 1'b0, ev(0,0,2'b00,0,1,1,0,0,0,1,2'b00,0,3'd3));
        cyc("lw mem1", 1'b0, I_LW, 1'b0, ev(0,0,2'b00,0,1,1,0,0,0,1,2'b00,0,3'd3));
        cyc("lw wb",   1'b0, I_LW, 1'b0, ev(0,1,2'b00,1,0,0,0,0,0,1,2'b01,0,3'd4));

        for (int c = 0; c < 2; c++) begin
            fetch_decode("beq", I_BEQ, 1'(c));
            cyc(c == 0 ? "beq exec cmp0" : "beq exec cmp1", 1'b0, I_BEQ, 1'(c),
                ev(0,1,2'b11,0,0,0,0,0,0,0,2'b00,0,3'd2));
        end

        fetch_decode("sb", I_SB, 1'b0);
        cyc("sb exec", 1'b0, I_SB, 1'b0, ev(0,0,2'b00,0,1,0,0,0,0,0,2'b00,0,3'd2));
        cyc("sb mem0", 1'b0, I_SB, 1'b0, ev(0,0,2'b00,0,1,0,1,1,0,0,2'b00,0,3'd3));
        cyc("sb mem1", 1'b0, I_SB, 1'b0, ev(0,1,2'b00,0,1,0,1,1,0,0,2'b00,0,3'd3));

        fetch_decode("jal", I_JAL, 1'b0);
        cyc("jal exec", 1'b0, I_JAL, 1'b0, ev(0,1,2'b01,1,0,0,0,0,0,0,2'b10,0,3'd2));
        fetch_decode("jalr", I_JALR, 1'b0);
        cyc("jalr exec", 1'b0, I_JALR, 1'b0, ev(0,1,2'b10,1,1,0,0,0,0,0,2'b10,0,3'd2));
        fetch_decode("lui", I_LUI, 1'b0);
        cyc("lui exec", 1'b0, I_LUI, 1'b0, ev(0,1,2'b00,1,0,0,0,0,0,0,2'b11,0,3'd2));

        // Reset in the middle of a load: nothing asserted that cycle, clean restart after.
        fetch_decode("lw2", I_LW, 1'b0);
        cyc("lw2 exec", 1'b0, I_LW, 1'b0, ev(0,0,2'b00,0,1,0,0,0,0,0,2'b00,0,3'd2));
        cyc("lw2 mem0", 1'b0, I_LW, 1'b0, ev(0,0,2'b00,0,1,1,0,0,0,1,2'b00,0,3'd3));
        cyc("mid reset", 1'b1, I_LW, 1'b0, E_ZERO);
        fetch_decode("add2", I_ADD, 1'b0);
        cyc("add2 exec", 1'b0, I_ADD, 1'b0, ev(0,1,2'b00,1,0,0,0,0,0,0,2'b00,0,3'd2));

        fetch_decode("bad", I_BAD, 1'b0);
`ifdef ILLEGAL_TRAP_EN
        cyc("bad exec", 1'b0, I_BAD, 1'b0, ev(0,0,2'b00,0,0,0,0,0,0,0,2'b00,0,3'd2));
        for (int k = 0; k < 3; k++)
            cyc("halt hold", 1'b0, I_BAD, 1'b0, ev(0,0,2'b00,0,0,0,0,0,0,0,2'b00,1,3'd5));
        cyc("halt reset", 1'b1, I_BAD, 1'b0, E_ZERO);
        cyc("halt exit", 1'b0, I_ADD, 1'b0, E_FETCH);
`else
        cyc("bad exec nop", 1'b0, I_BAD, 1'b0, ev(0,1,2'b00,0,0,0,0,0,0,0,2'b00,0,3'd2));
        cyc("bad next fetch", 1'b0, I_ADD, 1'b0, E_FETCH);
`endif

        repeat (3) @(posedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: got %0d pending required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
